uma_arbiter: RTL and testbench

UMA_ARBITER -- requirements
Module: uma_arbiter

---
 rtl/uma_arbiter.sv | 159 +++++++++++++++
 tb/tb_uma_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uma_arbiter.sv
// rtl/uma_arbiter.sv - multi-channel unified memory arbiter with per-channel pending slots
// Fixed priority with starvation promotion (MODE 0) or round-robin (MODE 1).
module uma_arbiter #(
    parameter int CH_COUNT   = 2,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = 0,
    parameter int MAX_WAIT   = 15
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic [CH_COUNT-1:0]                 REQ,
    input  logic [CH_COUNT-1:0]                 WE,
    input  logic [CH_COUNT*ADDR_WIDTH-1:0]      ADDR,
    input  logic [CH_COUNT*ADDR_WIDTH-1:0]      BASE,
    input  logic [CH_COUNT*DATA_WIDTH-1:0]      DIN,
    input  logic [CH_COUNT*(DATA_WIDTH/8)-1:0]  BE,
    output logic [CH_COUNT-1:0]                 ACK,
    output logic [DATA_WIDTH-1:0]               RDATA,
    output logic [CH_COUNT-1:0]                 OVERRUN,
    output logic                                M_REQ,
    output logic                                M_WE,
    output logic [ADDR_WIDTH-1:0]               M_ADDR,
    output logic [DATA_WIDTH-1:0]               M_DIN,
    output logic [DATA_WIDTH/8-1:0]             M_BE,
    input  logic                                M_ACK,
    input  logic [DATA_WIDTH-1:0]               M_DOUT
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int IW = $clog2(CH_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  state;
    logic [CH_COUNT-1:0]     pend;
    logic                    we_q   [CH_COUNT];
    logic [ADDR_WIDTH-1:0]   addr_q [CH_COUNT];
    logic [DATA_WIDTH-1:0]   din_q  [CH_COUNT];
    logic [BW-1:0]           be_q   [CH_COUNT];
    logic [7:0]              wait_cnt [CH_COUNT];
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           g;

    logic [IW-1:0]           win;
    logic                    found;
    int                      rr_idx;
    logic [ADDR_WIDTH-1:0]   win_addr;

    // Starved channels are searched before the plain priority scan.
    always_comb begin
        win    = '0;
        found  = 1'b0;
        rr_idx = 0;
        if (MODE == 1) begin
            for (int k = 0; k < CH_COUNT; k++) begin
                rr_idx = (int'(rr_ptr) + k) % CH_COUNT;
                if (!found && pend[rr_idx]) begin
                    win   = IW'(rr_idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < CH_COUNT; i++) begin
                if (!found && pend[i] && wait_cnt[i] == 8'(MAX_WAIT)) begin
                    win   = IW'(i);
                    found = 1'b1;
                end
            end
            for (int i = 0; i < CH_COUNT; i++) begin
                if (!found && pend[i]) begin
                    win   = IW'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign win_addr = BASE[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] + addr_q[win];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            pend    <= '0;
            OVERRUN <= '0;
            rr_ptr  <= '0;
            g       <= '0;
            ACK     <= '0;
            RDATA   <= '0;
            M_REQ   <= 1'b0;
            M_WE    <= 1'b0;
            M_ADDR  <= '0;
            M_DIN   <= '0;
            M_BE    <= '0;
            for (int i = 0; i < CH_COUNT; i++) begin
                we_q[i]     <= 1'b0;
                addr_q[i]   <= '0;
                din_q[i]    <= '0;
                be_q[i]     <= '0;
                wait_cnt[i] <= '0;
            end
        end else begin
            // A strobe in the DONE cycle of the same channel refills the slot.
            for (int i = 0; i < CH_COUNT; i++) begin
                if (REQ[i]) begin
                    if (pend[i] && !(state == S_DONE && g == IW'(i))) begin
                        OVERRUN[i] <= 1'b1;
                    end else begin
                        pend[i]   <= 1'b1;
                        we_q[i]   <= WE[i];
                        addr_q[i] <= ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                        din_q[i]  <= DIN[i*DATA_WIDTH +: DATA_WIDTH];
                        be_q[i]   <= BE[i*BW +: BW];
                    end
                end else if (state == S_DONE && g == IW'(i)) begin
                    pend[i] <= 1'b0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        g      <= win;
                        M_REQ  <= 1'b1;
                        M_WE   <= we_q[win];
                        M_ADDR <= win_addr;
                        M_DIN  <= din_q[win];
                        M_BE   <= be_q[win];
                        rr_ptr <= (int'(win) == CH_COUNT - 1) ? '0 : win + 1'b1;
                        for (int i = 0; i < CH_COUNT; i++) begin
                            if (IW'(i) == win)
                                wait_cnt[i] <= '0;
                            else if (pend[i] && wait_cnt[i] != 8'(MAX_WAIT))
                                wait_cnt[i] <= wait_cnt[i] + 8'd1;
                        end
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (M_ACK) begin
                        M_REQ  <= 1'b0;
                        M_WE   <= 1'b0;
                        M_ADDR <= '0;
                        M_DIN  <= '0;
                        M_BE   <= '0;
                        ACK    <= {{(CH_COUNT-1){1'b0}}, 1'b1} << g;
                        RDATA  <= M_DOUT;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    ACK   <= '0;
                    RDATA <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uma_arbiter.sv
// tb/tb_uma_arbiter.sv - directed self-checking bench for uma_arbiter
// Instance a: 2 channels, fixed priority, MAX_WAIT=2. Instance b: 4 channels, round-robin.
module tb_uma_arbiter;
    logic        clk;
    logic        rst;

    logic [1:0]  req_a, we_a, ack_a, ovr_a;
    logic [45:0] addr_a, base_a;
    logic [63:0] din_a;
    logic [7:0]  be_a;
    logic [31:0] rdata_a, m_din_a, m_dout_a;
    logic        m_req_a, m_we_a, m_ack_a;
    logic [22:0] m_addr_a;
    logic [3:0]  m_be_a;

    logic [3:0]   req_b, we_b, ack_b, ovr_b;
    logic [91:0]  addr_b, base_b;
    logic [127:0] din_b;
    logic [15:0]  be_b;
    logic [31:0]  rdata_b, m_din_b, m_dout_b;
    logic         m_req_b, m_we_b, m_ack_b;
    logic [22:0]  m_addr_b;
    logic [3:0]   m_be_b;

    int checks;
    int errors;

    uma_arbiter #(.CH_COUNT(2), .ADDR_WIDTH(23), .DATA_WIDTH(32), .MODE(0), .MAX_WAIT(2)) u_a (
        .CLK(clk), .RESET(rst), .REQ(req_a), .WE(we_a), .ADDR(addr_a), .BASE(base_a),
        .DIN(din_a), .BE(be_a), .ACK(ack_a), .RDATA(rdata_a), .OVERRUN(ovr_a),
        .M_REQ(m_req_a), .M_WE(m_we_a), .M_ADDR(m_addr_a), .M_DIN(m_din_a), .M_BE(m_be_a),
        .M_ACK(m_ack_a), .M_DOUT(m_dout_a));

    uma_arbiter #(.CH_COUNT(4), .ADDR_WIDTH(23), .DATA_WIDTH(32), .MODE(1), .MAX_WAIT(15)) u_b (
        .CLK(clk), .RESET(rst), .REQ(req_b), .WE(we_b), .ADDR(addr_b), .BASE(base_b),
        .DIN(din_b), .BE(be_b), .ACK(ack_b), .RDATA(rdata_b), .OVERRUN(ovr_b),
        .M_REQ(m_req_b), .M_WE(m_we_b), .M_ADDR(m_addr_b), .M_DIN(m_din_b), .M_BE(m_be_b),
        .M_ACK(m_ack_b), .M_DOUT(m_dout_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        req_a = '0; we_a = '0; addr_a = '0; base_a = '0; din_a = '0; be_a = '0;
        m_ack_a = 1'b0; m_dout_a = '0;
        req_b = '0; we_b = '0; addr_b = '0; base_b = '0; din_b = '0; be_b = '0;
        m_ack_b = 1'b0; m_dout_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory responder: waits for M_REQ, answers after lat cycles, optionally re-strobes in DONE.
    task automatic access(input int which, input int lat, input logic [31:0] dout,
                          input logic [1:0] restrobe, output logic [3:0] ack_s,
                          output logic [22:0] addr_s, output logic [31:0] din_s,
                          output logic we_s, output logic [31:0] rdata_s);
        bit got;
        got = 1'b0;
        ack_s = '0; addr_s = '0; din_s = '0; we_s = 1'b0; rdata_s = '0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if ((which == 0) ? m_req_a : m_req_b) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL access_timeout dut%0d: M_REQ stayed 0, required 1", which);
            return;
        end
        addr_s = (which == 0) ? m_addr_a : m_addr_b;
        din_s  = (which == 0) ? m_din_a : m_din_b;
        we_s   = (which == 0) ? m_we_a : m_we_b;
        repeat (lat - 1) @(negedge clk);
        if (which == 0) begin m_ack_a = 1'b1; m_dout_a = dout; end
        else begin m_ack_b = 1'b1; m_dout_b = dout; end
        @(negedge clk);
        m_ack_a = 1'b0; m_ack_b = 1'b0;
        ack_s   = (which == 0) ? {2'b00, ack_a} : ack_b;
        rdata_s = (which == 0) ? rdata_a : rdata_b;
        req_a   = restrobe;
        @(negedge clk);
        req_a = '0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (ack_a !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", ack_a); end
        checks++; if (m_req_a !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b want 0", m_req_a); end
        checks++; if (m_addr_a !== 23'h0) begin errors++; $display("FAIL reset_maddr got %h want 0", m_addr_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_a); end
        checks++; if (ovr_a !== 2'b00) begin errors++; $display("FAIL reset_overrun got %b want 00", ovr_a); end
        checks++; if (m_req_b !== 1'b0) begin errors++; $display("FAIL reset_mreq_b got %b want 0", m_req_b); end
        m_ack_a = 1'b1; m_dout_a = 32'h12345678;
        @(negedge clk);
        m_ack_a = 1'b0;
        @(negedge clk);
        checks++; if (ack_a !== 2'b00) begin errors++; $display("FAIL idle_mack_ack got %b want 00", ack_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL idle_mack_rdata got %h want 0", rdata_a); end
    endtask

    task automatic test_basic_read();
        do_reset();
        req_a = 2'b01; we_a = 2'b00; addr_a[22:0] = 23'h10; base_a[22:0] = 23'h100; be_a[3:0] = 4'hA;
        @(negedge clk);
        req_a = 2'b00;
        checks++; if (m_req_a !== 1'b0) begin errors++; $display("FAIL lat_n1_mreq got %b want 0", m_req_a); end
        @(negedge clk);
        checks++; if (m_req_a !== 1'b1) begin errors++; $display("FAIL lat_n2_mreq got %b want 1", m_req_a); end
        checks++; if (m_addr_a !== 23'h110) begin errors++; $display("FAIL basic_maddr got %h want 110", m_addr_a); end
        checks++; if (m_we_a !== 1'b0) begin errors++; $display("FAIL basic_mwe got %b want 0", m_we_a); end
        checks++; if (m_be_a !== 4'hA) begin errors++; $display("FAIL basic_mbe got %h want a", m_be_a); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (m_req_a !== 1'b1) begin errors++; $display("FAIL busy_hold_mreq got %b want 1", m_req_a); end
        end
        @(negedge clk);
        m_ack_a = 1'b1; m_dout_a = 32'hDEADBEEF;
        @(negedge clk);
        m_ack_a = 1'b0; m_dout_a = 32'h0;
        checks++; if (ack_a !== 2'b01) begin errors++; $display("FAIL basic_ack got %b want 01", ack_a); end
        checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata got %h want deadbeef", rdata_a); end
        checks++; if (m_req_a !== 1'b0) begin errors++; $display("FAIL mreq_drop got %b want 0", m_req_a); end
        @(negedge clk);
        checks++; if (ack_a !== 2'b00) begin errors++; $display("FAIL ack_one_cycle got %b want 00", ack_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL rdata_clear got %h want 0", rdata_a); end
    endtask

    task automatic test_starvation();
        logic [3:0]  ack_s;
        logic [22:0] addr_s;
        logic [31:0] din_s, rd_s;
        logic        we_s;
        logic [3:0]  want [4];
        want[0] = 4'b0001; want[1] = 4'b0001; want[2] = 4'b0010; want[3] = 4'b0001;
        do_reset();
        req_a = 2'b11;
        @(negedge clk);
        req_a = 2'b00;
        for (int k = 0; k < 4; k++) begin
            access(0, 2, 32'h100 + k, (k < 2) ? 2'b01 : 2'b00, ack_s, addr_s, din_s, we_s, rd_s);
            checks++;
            if (ack_s !== want[k]) begin
                errors++; $display("FAIL starve_order arb%0d got %b want %b", k + 1, ack_s, want[k]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [3:0]  ack_s;
        logic [22:0] addr_s;
        logic [31:0] din_s, rd_s;
        logic        we_s;
        do_reset();
        base_a[45:23] = 23'h200; addr_a[45:23] = 23'h5;
        req_a = 2'b10; we_a = 2'b10; din_a[63:32] = 32'h11111111;
        @(negedge clk);
        din_a[63:32] = 32'h22222222;
        @(negedge clk);
        din_a[63:32] = 32'h33333333;
        @(negedge clk);
        req_a = 2'b00;
        access(0, 1, 32'hCAFEF00D, 2'b00, ack_s, addr_s, din_s, we_s, rd_s);
        checks++; if (din_s !== 32'h11111111) begin errors++; $display("FAIL ovr_din got %h want 11111111", din_s); end
        checks++; if (we_s !== 1'b1) begin errors++; $display("FAIL ovr_we got %b want 1", we_s); end
        checks++; if (addr_s !== 23'h205) begin errors++; $display("FAIL ovr_addr got %h want 205", addr_s); end
        checks++; if (ack_s !== 4'b0010) begin errors++; $display("FAIL ovr_ack got %b want 0010", ack_s); end
        checks++; if (rd_s !== 32'hCAFEF00D) begin errors++; $display("FAIL write_rdata got %h want cafef00d", rd_s); end
        repeat (5) @(negedge clk);
        checks++; if (m_req_a !== 1'b0) begin errors++; $display("FAIL ovr_single_access got %b want 0", m_req_a); end
        checks++; if (ovr_a !== 2'b10) begin errors++; $display("FAIL ovr_sticky got %b want 10", ovr_a); end
    endtask

    task automatic test_wrap();
        logic [3:0]  ack_s;
        logic [22:0] addr_s;
        logic [31:0] din_s, rd_s;
        logic        we_s;
        do_reset();
        base_a[22:0] = 23'h7FFFFC; addr_a[22:0] = 23'h8;
        req_a = 2'b01;
        @(negedge clk);
        req_a = 2'b00;
        access(0, 1, 32'h0, 2'b00, ack_s, addr_s, din_s, we_s, rd_s);
        checks++; if (addr_s !== 23'h4) begin errors++; $display("FAIL addr_wrap got %h want 4", addr_s); end
    endtask

    task automatic test_reset_busy();
        bit got;
        do_reset();
        got = 1'b0;
        req_a = 2'b01;
        @(negedge clk);
        req_a = 2'b00;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (m_req_a) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL rstbusy_mreq got 0 want 1"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ack_a = 1'b1; m_dout_a = 32'hBAD0BAD0;
        @(negedge clk);
        m_ack_a = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if (ack_a !== 2'b00 || m_req_a !== 1'b0) begin
                errors++; $display("FAIL rstbusy_quiet cyc%0d got ack=%b mreq=%b want ack=00 mreq=0", n, ack_a, m_req_a);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  ack_s;
        logic [22:0] addr_s;
        logic [31:0] din_s, rd_s;
        logic        we_s;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            base_b[i*23 +: 23] = 23'(i * 32'h1000);
            addr_b[i*23 +: 23] = 23'(i);
        end
        for (int r = 0; r < 2; r++) begin
            req_b = 4'b1111;
            @(negedge clk);
            req_b = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                access(1, 1, 32'hA0 + k, 2'b00, ack_s, addr_s, din_s, we_s, rd_s);
                checks++;
                if (ack_s !== (4'b0001 << k)) begin
                    errors++; $display("FAIL rr_ack round%0d slot%0d got %b want %b", r, k, ack_s, 4'b0001 << k);
                end
                checks++;
                if (addr_s !== 23'(k * 32'h1001)) begin
                    errors++; $display("FAIL rr_addr round%0d slot%0d got %h want %h", r, k, addr_s, 23'(k * 32'h1001));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_read();
        test_starvation();
        test_overrun();
        test_wrap();
        test_reset_busy();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
